// File: rtl/l1_cache_ctrl_unit.sv
// Miss-handling FSM plus read-word select and write merge for the direct-mapped write-back L1.
// Hits cost zero cycles; misses stall the CPU through writeback/allocate/refill, paced by mem_ack.
module l1_cache_ctrl_unit #(
  parameter int LINE_W = 256,
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cache_cs,
  input  logic              cache_we,
  input  logic              cache_hit,
  input  logic              cache_dirty,
  input  logic              mem_ack,
  input  logic [2:0]        block_offset,
  input  logic [WORD_W-1:0] cpu_data_i,
  input  logic [LINE_W-1:0] cache_line_i,
  input  logic [LINE_W-1:0] mem_line_i,
  output logic [WORD_W-1:0] cpu_data_o,
  output logic [LINE_W-1:0] sram_line_o,
  output logic              sram_dirty_o,
  output logic              sram_cs,
  output logic              sram_we,
  output logic              stall,
  output logic              mem_cs,
  output logic              mem_we,
  output logic              mem_wb,
  output logic [LINE_W-1:0] mem_line_o
);

  localparam int NWORDS = 8;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WRITEBACK = 2'd1,
    S_ALLOCATE  = 2'd2,
    S_REFILL    = 2'd3
  } state_t;

  state_t state, state_nxt;
  logic [LINE_W-1:0] merged_line;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Busy states ignore cache_cs/cache_we: the stalled CPU is holding its request.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (cache_cs && !cache_hit)
          state_nxt = cache_dirty ? S_WRITEBACK : S_ALLOCATE;
      end
      S_WRITEBACK: if (mem_ack) state_nxt = S_ALLOCATE;
      S_ALLOCATE:  if (mem_ack) state_nxt = S_REFILL;
      S_REFILL:    state_nxt = S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase
  end

  // Word 0 sits in the most significant slot of the line.
  always_comb begin
    cpu_data_o  = '0;
    merged_line = cache_line_i;
    for (int k = 0; k < NWORDS; k++) begin
      if (block_offset == 3'(k)) begin
        cpu_data_o = cache_line_i[LINE_W-1-WORD_W*k -: WORD_W];
        merged_line[LINE_W-1-WORD_W*k -: WORD_W] = cpu_data_i;
      end
    end
  end

  assign sram_line_o = (state == S_REFILL) ? mem_line_i : merged_line;
  assign mem_line_o  = cache_line_i;

  always_comb begin
    sram_cs      = 1'b0;
    sram_we      = 1'b0;
    sram_dirty_o = 1'b0;
    stall        = 1'b0;
    mem_cs       = 1'b0;
    mem_we       = 1'b0;
    mem_wb       = 1'b0;
    if (!rst) begin
      case (state)
        S_IDLE: begin
          sram_cs = cache_cs;
          stall   = cache_cs && !cache_hit;
          if (cache_cs && cache_hit && cache_we) begin
            sram_we      = 1'b1;
            sram_dirty_o = 1'b1;
          end
        end
        S_WRITEBACK: begin
          stall   = 1'b1;
          mem_cs  = 1'b1;
          mem_we  = 1'b1;
          mem_wb  = 1'b1;
          sram_cs = 1'b1;
        end
        S_ALLOCATE: begin
          stall  = 1'b1;
          mem_cs = 1'b1;
        end
        S_REFILL: begin
          stall   = 1'b1;
          sram_cs = 1'b1;
          sram_we = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_l1_cache_ctrl_unit.sv
// Directed bench for l1_cache_ctrl_unit: a per-cycle reference model plus literal spot checks.
module tb_l1_cache_ctrl_unit;

  logic         clk = 1'b0;
  logic         rst, cache_cs, cache_we, cache_hit, cache_dirty, mem_ack;
  logic [2:0]   block_offset;
  logic [31:0]  cpu_data_i;
  logic [255:0] cache_line_i, mem_line_i;
  logic [31:0]  cpu_data_o;
  logic [255:0] sram_line_o, mem_line_o;
  logic         sram_dirty_o, sram_cs, sram_we, stall, mem_cs, mem_we, mem_wb;

  int checks = 0;
  int errors = 0;
  int stall_total = 0;

  l1_cache_ctrl_unit dut (
    .clk(clk), .rst(rst), .cache_cs(cache_cs), .cache_we(cache_we),
    .cache_hit(cache_hit), .cache_dirty(cache_dirty), .mem_ack(mem_ack),
    .block_offset(block_offset), .cpu_data_i(cpu_data_i),
    .cache_line_i(cache_line_i), .mem_line_i(mem_line_i),
    .cpu_data_o(cpu_data_o), .sram_line_o(sram_line_o), .sram_dirty_o(sram_dirty_o),
    .sram_cs(sram_cs), .sram_we(sram_we), .stall(stall), .mem_cs(mem_cs),
    .mem_we(mem_we), .mem_wb(mem_wb), .mem_line_o(mem_line_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] word_of(input logic [255:0] line, input int off);
    return 32'(line >> (32 * (7 - off)));
  endfunction

  function automatic logic [255:0] merge_of(input logic [255:0] line, input int off,
                                            input logic [31:0] w);
    logic [255:0] mask;
    mask = {224'd0, 32'hFFFF_FFFF} << (32 * (7 - off));
    return (line & ~mask) | ({224'd0, w} << (32 * (7 - off)));
  endfunction

  // Reference model: which phase of miss handling the cache is in.
  localparam int P_IDLE = 0, P_WB = 1, P_ALLOC = 2, P_REFILL = 3;
  int  phase = P_IDLE;
  bit  model_ok = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      phase    = P_IDLE;
      model_ok = 1'b1;
    end else if (phase == P_IDLE) begin
      if (cache_cs && !cache_hit) phase = cache_dirty ? P_WB : P_ALLOC;
    end else if (phase == P_WB) begin
      if (mem_ack) phase = P_ALLOC;
    end else if (phase == P_ALLOC) begin
      if (mem_ack) phase = P_REFILL;
    end else begin
      phase = P_IDLE;
    end
  end

  always @(negedge clk) begin
    logic e_scs, e_swe, e_stall, e_mcs, e_mwe, e_mwb, wr_hit;
    logic [255:0] e_line;
    if (stall) stall_total++;
    if (model_ok) begin
      wr_hit  = (phase == P_IDLE) && cache_cs && cache_hit && cache_we;
      e_scs   = (phase == P_IDLE) ? cache_cs : (phase != P_ALLOC);
      e_swe   = wr_hit || (phase == P_REFILL);
      e_stall = (phase != P_IDLE) || (cache_cs && !cache_hit);
      e_mcs   = (phase == P_WB) || (phase == P_ALLOC);
      e_mwe   = (phase == P_WB);
      e_mwb   = (phase == P_WB);
      if (rst) {e_scs, e_swe, e_stall, e_mcs, e_mwe, e_mwb} = '0;
      e_line = (phase == P_REFILL) ? mem_line_i
                                   : merge_of(cache_line_i, int'(block_offset), cpu_data_i);
      chk("m_cpu_data", 256'(cpu_data_o), 256'(word_of(cache_line_i, int'(block_offset))));
      chk("m_mem_line", mem_line_o, cache_line_i);
      chk("m_sram_line", sram_line_o, e_line);
      chk("m_strobes", 256'({sram_cs, sram_we, stall, mem_cs, mem_we, mem_wb}),
          256'({e_scs, e_swe, e_stall, e_mcs, e_mwe, e_mwb}));
      if (sram_we && !rst)
        chk("m_dirty", 256'(sram_dirty_o), 256'(phase == P_IDLE));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int s0;
    logic [255:0] line, sweep;
    rst = 1'b1; cache_cs = 1'b1; cache_we = 1'b0; cache_hit = 1'b0; cache_dirty = 1'b1;
    mem_ack = 1'b0; block_offset = 3'd0; cpu_data_i = '0;
    cache_line_i = '0; mem_line_i = '0;
    cyc(); cyc();
    @(negedge clk);
    chk("rst_strobes", 256'({sram_cs, sram_we, stall, mem_cs, mem_we, mem_wb}), 256'd0);
    cyc();
    rst = 1'b0; cache_cs = 1'b0; cache_dirty = 1'b0;

    // 1: read hit
    for (int k = 0; k < 8; k++) line[255-32*k -: 32] = 32'h0101_0101 * k;
    line[255-32*5 -: 32] = 32'hDEAD_BEEF;
    cache_line_i = line; cache_cs = 1'b1; cache_hit = 1'b1; block_offset = 3'd5;
    @(negedge clk);
    chk("t1_data", 256'(cpu_data_o), 256'(32'hDEAD_BEEF));
    chk("t1_stall_we", 256'({stall, sram_we}), 256'd0);
    cyc();

    // 2: write hit at offset 0
    cache_line_i = {8{32'hAAAA_AAAA}}; cache_we = 1'b1; block_offset = 3'd0;
    cpu_data_i = 32'h1234_5678;
    @(negedge clk);
    chk("t2_line", sram_line_o, {32'h1234_5678, {7{32'hAAAA_AAAA}}});
    chk("t2_we_dirty_stall", 256'({sram_we, sram_dirty_o, stall}), 256'(3'b110));
    cyc();

    // 3: clean read miss, mem_ack on the third ALLOCATE cycle
    for (int k = 0; k < 8; k++) line[255-32*k -: 32] = 32'h1000_0000 + k;
    mem_line_i = line; cache_line_i = {8{32'h5555_5555}};
    cache_we = 1'b0; cache_hit = 1'b0; cache_dirty = 1'b0; block_offset = 3'd2;
    s0 = stall_total;
    @(negedge clk);
    chk("t3_stall_now", 256'(stall), 256'd1);
    cyc(); cyc(); cyc();
    mem_ack = 1'b1;
    @(negedge clk);
    chk("t3_alloc", 256'({mem_cs, mem_we}), 256'(2'b10));
    cyc();
    mem_ack = 1'b0;
    @(negedge clk);
    chk("t3_refill_line", sram_line_o, line);
    chk("t3_refill_we", 256'(sram_we), 256'd1);
    cyc();
    cache_hit = 1'b1; cache_line_i = line;
    @(negedge clk);
    chk("t3_hit_data", 256'(cpu_data_o), 256'(32'h1000_0002));
    chk("t3_hit_stall", 256'(stall), 256'd0);
    cyc();
    chk("t3_stall_cycles", 256'(stall_total - s0), 256'd5);
    cache_cs = 1'b0;

    // 4: dirty write miss: 2 WRITEBACK + 2 ALLOCATE cycles
    cyc();
    cache_cs = 1'b1; cache_we = 1'b1; cache_hit = 1'b0; cache_dirty = 1'b1;
    block_offset = 3'd3; cpu_data_i = 32'hCAFE_F00D;
    cache_line_i = {8{32'h7777_0000}}; mem_line_i = {8{32'h3333_3333}};
    s0 = stall_total;
    cyc();
    @(negedge clk);
    chk("t4_wb", 256'({mem_cs, mem_we, mem_wb}), 256'(3'b111));
    chk("t4_wb_data", mem_line_o, {8{32'h7777_0000}});
    cyc();
    mem_ack = 1'b1;
    cyc();
    mem_ack = 1'b0;
    cyc();
    mem_ack = 1'b1;
    cyc();
    mem_ack = 1'b0; cache_dirty = 1'b0;
    @(negedge clk);
    chk("t4_refill_dirty", 256'({sram_we, sram_dirty_o}), 256'(2'b10));
    cyc();
    cache_hit = 1'b1; cache_line_i = {8{32'h3333_3333}};
    @(negedge clk);
    chk("t4_merge", sram_line_o,
        {{3{32'h3333_3333}}, 32'hCAFE_F00D, {4{32'h3333_3333}}});
    chk("t4_we_dirty_stall", 256'({sram_we, sram_dirty_o, stall}), 256'(3'b110));
    cyc();
    chk("t4_stall_cycles", 256'(stall_total - s0), 256'd6);

    // 5: mux and merge sweep over word k = k
    for (int k = 0; k < 8; k++) sweep[255-32*k -: 32] = 32'(k);
    cache_line_i = sweep;
    for (int off = 0; off < 8; off++) begin
      cache_we = 1'b0; block_offset = 3'(off);
      @(negedge clk);
      chk("t5_mux", 256'(cpu_data_o), 256'(off));
      cyc();
      cache_we = 1'b1; cpu_data_i = 32'hFFFF_0000 | 32'(off);
      @(negedge clk);
      chk("t5_merge_delta", sram_line_o ^ sweep,
          256'(32'hFFFF_0000) << (32 * (7 - off)));
      cyc();
    end

    // 6: reset during ALLOCATE aborts the refill
    cache_we = 1'b0; cache_hit = 1'b0; cache_dirty = 1'b0;
    cyc(); cyc();
    rst = 1'b1;
    @(negedge clk);
    chk("t6_rst_strobes", 256'({sram_cs, sram_we, stall, mem_cs, mem_we, mem_wb}), 256'd0);
    cyc();
    rst = 1'b0; cache_hit = 1'b1; block_offset = 3'd6;
    @(negedge clk);
    chk("t6_after_rst", 256'({stall, mem_cs, sram_cs}), 256'(3'b001));
    chk("t6_data", 256'(cpu_data_o), 256'd6);
    cyc();
    cache_cs = 1'b0;
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
